// File: rtl/sp_issue_ctrl.sv
// sp_issue_ctrl: FIFO-buffered issue sequencer for SP, one instruction in flight; push to res_valid in 3 cycles.
// Host held off by host_ready=!full; results held until res_ready. Option macro: SP_ISSUE_READ_RESP_ONLY_EN.
module sp_issue_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        host_valid,
   output logic                        host_ready,
   input  logic [13:0]                 host_instr,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [7:0]                  res_data,
   output logic [1:0]                  res_op,
   output logic                        sp_in_valid,
   output logic [13:0]                 sp_instruction,
   input  logic                        sp_out_valid,
   input  logic [7:0]                  sp_out,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        timeout_err,
   output logic                        idle
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = $clog2(TIMEOUT);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]    state;
   logic [13:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [WW-1:0] wdog;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          drop_res;

   assign full       = (fifo_count == CW'(FIFO_DEPTH));
   assign empty      = (fifo_count == '0);
   assign host_ready = !full;
   assign push       = host_valid && !full;
   assign idle       = (state == IDLE) && empty;

`ifdef SP_ISSUE_READ_RESP_ONLY_EN
   // Only read results are worth handing to the host; others just retire.
   assign drop_res = sp_out_valid && (sp_instruction[13:12] != 2'b11);
`else
   assign drop_res = 1'b0;
`endif

   // Every pop is a transition into ISSUE, so this is also the issue strobe.
   always_comb begin
      pop = 1'b0;
      case (state)
         IDLE:    pop = !empty;
         WAIT:    pop = drop_res && !empty;
         RESP:    pop = res_ready && !empty;
         default: pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= host_instr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_count     <= '0;
         wdog           <= '0;
         sp_in_valid    <= 1'b0;
         sp_instruction <= '0;
         res_valid      <= 1'b0;
         res_data       <= '0;
         res_op         <= '0;
         timeout_err    <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            fifo_count <= fifo_count + CW'(1);
         else if (pop && !push)
            fifo_count <= fifo_count - CW'(1);

         case (state)
            ISSUE: begin
               state       <= WAIT;
               sp_in_valid <= 1'b0;
               wdog        <= '0;
            end
            WAIT: begin
               if (sp_out_valid) begin
                  if (drop_res) begin
                     state <= IDLE;
                  end else begin
                     state     <= RESP;
                     res_valid <= 1'b1;
                     res_data  <= sp_out;
                     res_op    <= sp_instruction[13:12];
                  end
               end else if (wdog == WW'(TIMEOUT - 1)) begin
                  state       <= RESP;
                  res_valid   <= 1'b1;
                  res_data    <= 8'h00;
                  res_op      <= sp_instruction[13:12];
                  timeout_err <= 1'b1;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
            end
         endcase

         // Issue overrides the per-state next state chosen above.
         if (pop) begin
            state          <= ISSUE;
            sp_instruction <= mem[rd_ptr];
            sp_in_valid    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sp_issue_ctrl.sv
// Directed bench for sp_issue_ctrl with a one-cycle-latency SP register-file stand-in.
module tb_sp_issue_ctrl;
   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        host_valid;
   logic        host_ready;
   logic [13:0] host_instr;
   logic        res_valid;
   logic        res_ready;
   logic [7:0]  res_data;
   logic [1:0]  res_op;
   logic        sp_in_valid;
   logic [13:0] sp_instruction;
   logic        sp_out_valid;
   logic [7:0]  sp_out;
   logic [2:0]  fifo_count;
   logic        timeout_err;
   logic        idle;

   int n_chk = 0;
   int n_err = 0;
   int issued;
   int unstable;
   int hs;
   logic [7:0] last_data;
   logic [1:0] last_op;

   sp_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .host_valid(host_valid), .host_ready(host_ready), .host_instr(host_instr),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_op(res_op),
      .sp_in_valid(sp_in_valid), .sp_instruction(sp_instruction),
      .sp_out_valid(sp_out_valid), .sp_out(sp_out),
      .fifo_count(fifo_count), .timeout_err(timeout_err), .idle(idle)
   );

   always #5 clk = ~clk;

   // SP stand-in: load writes rd=[3:0] with imm, read returns rf[rs].
   logic [7:0] rf [16];
   logic       sp_dead;
   logic [1:0] sp_op;
   logic [3:0] sp_rs, sp_rt, sp_rd;
   logic [7:0] sp_imm;
   assign sp_op  = sp_instruction[13:12];
   assign sp_rs  = sp_instruction[11:8];
   assign sp_rt  = sp_instruction[7:4];
   assign sp_rd  = sp_instruction[3:0];
   assign sp_imm = sp_instruction[7:0];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_out_valid <= 1'b0;
         sp_out       <= 8'h00;
         for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      end else begin
         sp_out_valid <= 1'b0;
         if (sp_in_valid && !sp_dead) begin
            sp_out_valid <= 1'b1;
            case (sp_op)
               2'b00: begin
                  rf[sp_rd] <= 8'(rf[sp_rs] + rf[sp_rt]);
                  sp_out    <= 8'(rf[sp_rs] + rf[sp_rt]);
               end
               2'b01: begin
                  rf[sp_rd] <= 8'(rf[sp_rs] * rf[sp_rt]);
                  sp_out    <= 8'(rf[sp_rs] * rf[sp_rt]);
               end
               2'b10: begin
                  rf[sp_rd] <= sp_imm;
                  sp_out    <= sp_imm;
               end
               default: sp_out <= rf[sp_rs];
            endcase
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push(input logic [13:0] ins);
      host_valid = 1'b1;
      host_instr = ins;
      tick();
      host_valid = 1'b0;
   endtask

   task automatic wait_res(input string tag);
      int n = 0;
      while (!res_valid && n < 40) begin
         tick();
         n++;
      end
      check({tag, " res_valid"}, res_valid, 1);
   endtask

   initial begin
      rst        = 1'b1;
      host_valid = 1'b0;
      host_instr = '0;
      res_ready  = 1'b0;
      sp_dead    = 1'b0;
      repeat (2) tick();
      check("rst sp_in_valid", sp_in_valid, 0);
      check("rst res_valid", res_valid, 0);
      check("rst timeout_err", timeout_err, 0);
      check("rst fifo_count", fifo_count, 0);
      check("rst idle", idle, 1);
      check("rst host_ready", host_ready, 1);
      rst = 1'b0;
      tick();

`ifndef SP_ISSUE_READ_RESP_ONLY_EN
      // Latency: push at E0, issue after E1, result after E3.
      res_ready = 1'b1;
      push(14'h2805);
      check("lat E0 sp_in_valid", sp_in_valid, 0);
      check("lat E0 fifo_count", fifo_count, 1);
      tick();
      check("lat E1 sp_in_valid", sp_in_valid, 1);
      check("lat E1 sp_instruction", sp_instruction, 14'h2805);
      check("lat E1 fifo_count", fifo_count, 0);
      tick();
      check("lat E2 sp_in_valid", sp_in_valid, 0);
      check("lat E2 res_valid", res_valid, 0);
      tick();
      check("lat E3 res_valid", res_valid, 1);
      check("lat E3 res_data", res_data, 8'h05);
      check("lat E3 res_op", res_op, 2'b10);
      tick();
      check("lat E4 res_valid", res_valid, 0);
      check("lat E4 idle", idle, 1);

      // Result held under back-pressure, second instruction waits.
      res_ready = 1'b0;
      push(14'h2803);
      push(14'h0330);
      wait_res("hold first");
      check("hold first data", res_data, 8'h03);
      check("hold first op", res_op, 2'b10);
      issued   = 0;
      unstable = 0;
      repeat (6) begin
         tick();
         if (sp_in_valid) issued++;
         if (!res_valid || res_data !== 8'h03) unstable++;
      end
      check("hold no issue", issued, 0);
      check("hold stable", unstable, 0);
      check("hold fifo_count", fifo_count, 1);
      res_ready = 1'b1;
      tick();
      check("hold released", res_valid, 0);
      wait_res("hold second");
      check("hold second data", res_data, 8'h06);
      check("hold second op", res_op, 2'b00);
      tick();

      // Fill the FIFO behind a held result.
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(14'(14'h2811 + i));
      check("full fifo_count", fifo_count, 4);
      check("full host_ready", host_ready, 0);
      check("full res_data", res_data, 8'h11);
      push(14'h2899);
      check("full blocked push", fifo_count, 4);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("full one pop", fifo_count, 3);
      wait_res("full next");
      check("full next data", res_data, 8'h12);
      res_ready  = 1'b1;
      host_valid = 1'b1;
      host_instr = 14'h2816;
      tick();
      host_valid = 1'b0;
      check("push+pop fifo_count", fifo_count, 3);
      for (int i = 0; i < 4; i++) begin
         wait_res("drain");
         check("drain data", res_data, 32'h13 + 32'(i));
         tick();
      end
      tick();
      check("drain idle", idle, 1);
      check("drain fifo_count", fifo_count, 0);
`endif

      // Write then read r7: handshake count depends on the read-only option.
      res_ready = 1'b1;
      hs        = 0;
      last_data = '0;
      last_op   = '0;
      push(14'h2807);
      push(14'h3700);
      repeat (12) begin
         if (res_valid) begin
            hs++;
            last_data = res_data;
            last_op   = res_op;
         end
         tick();
      end
`ifdef SP_ISSUE_READ_RESP_ONLY_EN
      check("read handshakes", hs, 1);
`else
      check("read handshakes", hs, 2);
`endif
      check("read data", last_data, 8'h07);
      check("read op", last_op, 2'b11);
      check("read idle", idle, 1);

      // Watchdog: SP never answers.
      sp_dead   = 1'b1;
      res_ready = 1'b0;
      push(14'h3100);
      repeat (9) tick();
      check("wdog early res_valid", res_valid, 0);
      check("wdog early timeout_err", timeout_err, 0);
      tick();
      check("wdog res_valid", res_valid, 1);
      check("wdog res_data", res_data, 8'h00);
      check("wdog res_op", res_op, 2'b11);
      check("wdog timeout_err", timeout_err, 1);
      sp_dead   = 1'b0;
      res_ready = 1'b1;
      tick();
      push(14'h3700);
      wait_res("post wdog");
      check("post wdog data", res_data, 8'h07);
      check("post wdog sticky", timeout_err, 1);
      tick();

      // Asynchronous reset while waiting on SP.
      res_ready = 1'b0;
      push(14'h2820);
      push(14'h2821);
      tick();
      #2 rst = 1'b1;
      #1;
      check("arst sp_instruction", sp_instruction, 0);
      check("arst sp_in_valid", sp_in_valid, 0);
      check("arst res_valid", res_valid, 0);
      check("arst res_data", res_data, 0);
      check("arst res_op", res_op, 0);
      check("arst timeout_err", timeout_err, 0);
      check("arst fifo_count", fifo_count, 0);
      check("arst idle", idle, 1);
      tick();
      rst = 1'b0;
      issued = 0;
      repeat (5) begin
         tick();
         if (sp_in_valid) issued++;
      end
      check("arst no stale issue", issued, 0);
      check("arst idle after", idle, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
